multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one memory port, one ALU, and the PC/IR/MDR/ALUOut registers. It steps each instruction through fetch, decode, execute, memory and writeback states, driving all datapath select and write-enable lines. It handles variable-latency memory through a ready handshake. It traps on unsupported opcodes.

## Interface
Parameters:
- `OPW`, default 7: opcode width.

Ports:
- `iCLK`  in  1: clock; all state changes on the rising edge.
- `iRST_n`  in  1: reset, asynchronous, active-low.
- `iOPCODE`  in  OPW: IR[6:0]; valid from DECODE onward.
- `iZero`  in  1: ALU zero flag.
- `iMemReady`  in  1: memory completes the current access this cycle.
- `oPCWrite`  out  1: load PC.
- `oIRWrite`  out  1: load IR.
- `oIorD`  out  1: memory address select; 0 = PC, 1 = ALUOut.
- `oMemRead`  out  1: memory read request.
- `oMemWrite`  out  1: memory write request.
- `oRegWrite`  out  1: register file write enable.
- `oALUSrcA`  out  2: 00 = PC, 01 = rs1, 10 = OldPC.
- `oALUSrcB`  out  2: 00 = rs2, 01 = const 4, 10 = imm.
- `oALUOp`  out  2: 00 = add, 01 = sub, 10 = funct-decoded.
- `oMemtoReg`  out  2: 00 = ALUOut, 01 = MDR, 10 = PC.
- `oPCSource`  out  1: 0 = ALU result, 1 = ALUOut.
- `oIllegal`  out  1: sticky illegal-opcode flag.

## Operation
Supported opcodes: RTYPE 0110011, OPIMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111. Any other opcode goes to TRAP.

Every output not listed for a state is 0.

State outputs and transitions:
- IDLE: no outputs asserted; next state FETCH. This is the reset state.
- FETCH:
  - Outputs: IorD=0, MemRead=1, SrcA=00, SrcB=01, ALUOp=00, PCSource=0.
  - When iMemReady=1: IRWrite=1 and PCWrite=1, same cycle; next DECODE.
  - Otherwise stay in FETCH.
- DECODE: SrcA=10, SrcB=10, ALUOp=00 (branch/jump target into ALUOut). Next state by opcode:
  - RTYPE → EXEC_R
  - OPIMM → EXEC_I
  - LOAD/STORE → MEM_ADR
  - BRANCH → BRANCH
  - JAL → JAL
  - anything else → TRAP
- EXEC_R: SrcA=01, SrcB=00, ALUOp=10; next ALU_WB.
- EXEC_I: SrcA=01, SrcB=10, ALUOp=10; next ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=00; next FETCH.
- MEM_ADR: SrcA=01, SrcB=10, ALUOp=00; next MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: IorD=1, MemRead=1; wait for iMemReady, then next MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=01; next FETCH.
- MEM_WR: IorD=1, MemWrite=1; wait for iMemReady, then next FETCH.
- BRANCH: SrcA=01, SrcB=00, ALUOp=01, PCSource=1, PCWrite=iZero; next FETCH.
- JAL: RegWrite=1, MemtoReg=10 (PC already holds PC+4), PCSource=1, PCWrite=1; next FETCH.
- TRAP: oIllegal=1 and all other outputs 0; stays in TRAP until reset.

Rules:
- The opcode is sampled only in DECODE and MEM_ADR; its value in other states is ignored.
- MemRead and MemWrite are never asserted together.
- Memory request outputs are held stable while waiting for iMemReady.

## Timing
- Reset: asserting iRST_n low forces IDLE immediately, including mid-instruction or mid-wait. All outputs go to 0 and oIllegal clears.
- First FETCH: one cycle after iRST_n deasserts, the first rising edge moves IDLE→FETCH.
- Cycles per instruction, with zero memory wait:
  - RTYPE/OPIMM: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH: 3
  - JAL: 3
- Each wait cycle on a memory access adds 1 cycle.
- IRWrite, PCWrite (in FETCH and BRANCH) and oIllegal are combinational in state plus iMemReady/iZero. All other outputs depend on state only.
- iMemReady is ignored outside FETCH, MEM_RD and MEM_WR.

## Configuration
- `CYCLE_COUNT_EN` defined:
  - Adds outputs `oCycles` [31:0] and `oInstret` [31:0], both reset to 0.
  - oCycles increments every cycle not in IDLE or TRAP.
  - oInstret increments on every transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JAL.
  - Both counters wrap modulo 2^32.
- `CYCLE_COUNT_EN` undefined: neither port nor counter logic exists; behaviour is otherwise identical.

## Test plan
- Reset then iMemReady=1 constantly, iOPCODE=0110011:
  - Sequence IDLE, FETCH, DECODE, EXEC_R, ALU_WB, FETCH.
  - RegWrite=1 only in ALU_WB.
  - With the macro: oInstret=1 after 5 cycles.
- LOAD with iMemReady low for 2 cycles in both FETCH and MEM_RD:
  - Total 9 cycles.
  - IRWrite pulses exactly once.
  - MemRead and IorD stay stable through the waits.
  - RegWrite with MemtoReg=01 in MEM_WB.
- BRANCH:
  - iZero=1 → PCWrite=1 with PCSource=1 in the BRANCH cycle.
  - iZero=0 → PCWrite=0.
  - Both cases return to FETCH after 3 cycles.
- STORE then JAL:
  - MemWrite=1 with IorD=1 and MemRead=0.
  - JAL cycle shows RegWrite=1, MemtoReg=10, PCWrite=1.
- iOPCODE=1111111 at DECODE:
  - oIllegal=1 from the next cycle; stays in TRAP for 20 cycles with all other outputs 0.
  - With the macro, oCycles frozen.
- Drop iRST_n mid-MEM_RD wait:
  - All outputs 0 immediately, oIllegal cleared.
  - After release, FETCH follows after one IDLE cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for the shared multicycle RISC-V datapath.
// It steps each instruction through fetch, decode, execute, memory and writeback.
// Memory accesses stall on a ready handshake.
// Unsupported opcodes send the FSM to a sticky trap state that only reset leaves.
// Optional feature: define CYCLE_COUNT_EN to add the oCycles/oInstret performance counters.
module multicycle_control #(
  parameter int unsigned OPW = 7
) (
  input  logic           iCLK,
  input  logic           iRST_n,
  input  logic [OPW-1:0] iOPCODE,
  input  logic           iZero,
  input  logic           iMemReady,
  output logic           oPCWrite,
  output logic           oIRWrite,
  output logic           oIorD,
  output logic           oMemRead,
  output logic           oMemWrite,
  output logic           oRegWrite,
  output logic [1:0]     oALUSrcA,
  output logic [1:0]     oALUSrcB,
  output logic [1:0]     oALUOp,
  output logic [1:0]     oMemtoReg,
  output logic           oPCSource,
  output logic           oIllegal
`ifdef CYCLE_COUNT_EN
  ,
  output logic [31:0]    oCycles,
  output logic [31:0]    oInstret
`endif
);

  localparam logic [OPW-1:0] OpRtype  = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OpOpimm  = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OpLoad   = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OpStore  = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OpBranch = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OpJal    = OPW'(7'b1101111);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAdr,
    StMemRd, StMemWb, StMemWr, StBranch, StJal, StTrap
  } state_e;

  state_e state_q, state_d;

  // State register; reset drops straight back to idle, even mid-wait.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state and Moore outputs; only IRWrite/PCWrite look at iMemReady/iZero.
  always_comb begin
    state_d   = state_q;
    oPCWrite  = 1'b0;
    oIRWrite  = 1'b0;
    oIorD     = 1'b0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oRegWrite = 1'b0;
    oALUSrcA  = 2'b00;
    oALUSrcB  = 2'b00;
    oALUOp    = 2'b00;
    oMemtoReg = 2'b00;
    oPCSource = 1'b0;
    oIllegal  = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        oMemRead = 1'b1;
        oALUSrcB = 2'b01;
        if (iMemReady) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        // Precompute branch/jump target from the old PC into ALUOut.
        oALUSrcA = 2'b10;
        oALUSrcB = 2'b10;
        if (iOPCODE == OpRtype)                              state_d = StExecR;
        else if (iOPCODE == OpOpimm)                         state_d = StExecI;
        else if (iOPCODE == OpLoad || iOPCODE == OpStore)    state_d = StMemAdr;
        else if (iOPCODE == OpBranch)                        state_d = StBranch;
        else if (iOPCODE == OpJal)                           state_d = StJal;
        else                                                 state_d = StTrap;
      end
      StExecR: begin
        oALUSrcA = 2'b01;
        oALUOp   = 2'b10;
        state_d  = StAluWb;
      end
      StExecI: begin
        oALUSrcA = 2'b01;
        oALUSrcB = 2'b10;
        oALUOp   = 2'b10;
        state_d  = StAluWb;
      end
      StAluWb: begin
        oRegWrite = 1'b1;
        state_d   = StFetch;
      end
      StMemAdr: begin
        oALUSrcA = 2'b01;
        oALUSrcB = 2'b10;
        state_d  = (iOPCODE == OpStore) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        oIorD    = 1'b1;
        oMemRead = 1'b1;
        if (iMemReady) state_d = StMemWb;
      end
      StMemWb: begin
        oRegWrite = 1'b1;
        oMemtoReg = 2'b01;
        state_d   = StFetch;
      end
      StMemWr: begin
        oIorD     = 1'b1;
        oMemWrite = 1'b1;
        if (iMemReady) state_d = StFetch;
      end
      StBranch: begin
        oALUSrcA  = 2'b01;
        oALUOp    = 2'b01;
        oPCSource = 1'b1;
        oPCWrite  = iZero;
        state_d   = StFetch;
      end
      StJal: begin
        // PC already holds PC+4 from fetch; that is the link value.
        oRegWrite = 1'b1;
        oMemtoReg = 2'b10;
        oPCSource = 1'b1;
        oPCWrite  = 1'b1;
        state_d   = StFetch;
      end
      StTrap: oIllegal = 1'b1;
      default: state_d = StIdle;
    endcase
  end

`ifdef CYCLE_COUNT_EN
  logic retire;
  assign retire = (state_d == StFetch) &&
                  (state_q inside {StAluWb, StMemWb, StMemWr, StBranch, StJal});

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oCycles  <= 32'd0;
      oInstret <= 32'd0;
    end else begin
      if (state_q != StIdle && state_q != StTrap) oCycles <= oCycles + 32'd1;
      if (retire) oInstret <= oInstret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Outputs are packed into one 16-bit signature per state, with hand-computed values.
// Counter checks are compiled in when CYCLE_COUNT_EN is defined.
module tb_multicycle_control;

  logic       iCLK;
  logic       iRST_n;
  logic [6:0] iOPCODE;
  logic       iZero;
  logic       iMemReady;
  logic       oPCWrite, oIRWrite, oIorD, oMemRead, oMemWrite, oRegWrite, oPCSource, oIllegal;
  logic [1:0] oALUSrcA, oALUSrcB, oALUOp, oMemtoReg;
`ifdef CYCLE_COUNT_EN
  logic [31:0] oCycles, oInstret;
`endif

  multicycle_control #(.OPW(7)) dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iOPCODE   (iOPCODE),
    .iZero     (iZero),
    .iMemReady (iMemReady),
    .oPCWrite  (oPCWrite),
    .oIRWrite  (oIRWrite),
    .oIorD     (oIorD),
    .oMemRead  (oMemRead),
    .oMemWrite (oMemWrite),
    .oRegWrite (oRegWrite),
    .oALUSrcA  (oALUSrcA),
    .oALUSrcB  (oALUSrcB),
    .oALUOp    (oALUOp),
    .oMemtoReg (oMemtoReg),
    .oPCSource (oPCSource),
    .oIllegal  (oIllegal)
`ifdef CYCLE_COUNT_EN
    ,
    .oCycles   (oCycles),
    .oInstret  (oInstret)
`endif
  );

  // {PCWrite,IRWrite,IorD,MemRead,MemWrite,RegWrite,SrcA,SrcB,ALUOp,MemtoReg,PCSource,Illegal}
  logic [15:0] sig;
  assign sig = {oPCWrite, oIRWrite, oIorD, oMemRead, oMemWrite, oRegWrite,
                oALUSrcA, oALUSrcB, oALUOp, oMemtoReg, oPCSource, oIllegal};

  localparam logic [15:0] SIdle   = 16'h0000;
  localparam logic [15:0] SFetchW = 16'h1040;
  localparam logic [15:0] SFetchR = 16'hD040;
  localparam logic [15:0] SDecode = 16'h0280;
  localparam logic [15:0] SExecR  = 16'h0120;
  localparam logic [15:0] SExecI  = 16'h01A0;
  localparam logic [15:0] SAluWb  = 16'h0400;
  localparam logic [15:0] SMemAdr = 16'h0180;
  localparam logic [15:0] SMemRd  = 16'h3000;
  localparam logic [15:0] SMemWb  = 16'h0404;
  localparam logic [15:0] SMemWr  = 16'h2800;
  localparam logic [15:0] SBrT    = 16'h8112;
  localparam logic [15:0] SBrN    = 16'h0112;
  localparam logic [15:0] SJal    = 16'h840A;
  localparam logic [15:0] STrap   = 16'h0001;

  localparam logic [6:0] OpR  = 7'b0110011;
  localparam logic [6:0] OpI  = 7'b0010011;
  localparam logic [6:0] OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011;
  localparam logic [6:0] OpBr = 7'b1100011;
  localparam logic [6:0] OpJ  = 7'b1101111;
  localparam logic [6:0] OpX  = 7'b1111111;

  int checks = 0;
  int errors = 0;
  int ir_pulses;
  int unsigned model_cycles, model_instret;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Counter model follows the expected state of each cycle.
  task automatic chk_cnt(input string tag);
`ifdef CYCLE_COUNT_EN
    check({tag, "_cycles"}, oCycles, model_cycles);
    check({tag, "_instret"}, oInstret, model_instret);
`endif
  endtask

  // One cycle: drive ready, check the signature, then advance one edge.
  task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
    iMemReady = rdy;
    #1;
    check(tag, {16'd0, sig}, {16'd0, exp});
    check({tag, "_excl"}, {31'd0, oMemRead & oMemWrite}, 32'd0);
    if (oIRWrite) ir_pulses++;
    if (exp != SIdle && exp != STrap) model_cycles++;
    if (exp inside {SAluWb, SMemWb, SBrT, SBrN, SJal} || (exp == SMemWr && rdy))
      model_instret++;
    @(posedge iCLK);
    #1;
  endtask

  // Assert reset asynchronously, check immediate clear, release one edge later.
  task automatic do_reset(input string tag);
    iRST_n = 1'b0;
    #1;
    check(tag, {16'd0, sig}, 32'd0);
    model_cycles  = 0;
    model_instret = 0;
    chk_cnt(tag);
    @(posedge iCLK);
    #1;
    iRST_n = 1'b1;
  endtask

  initial begin
    iRST_n = 1'b1; iOPCODE = OpR; iZero = 1'b0; iMemReady = 1'b1;
    model_cycles = 0; model_instret = 0; ir_pulses = 0;
    #12;
    do_reset("reset");

    // RTYPE with no wait: IDLE, FETCH, DECODE, EXEC_R, ALU_WB, FETCH.
    iOPCODE = OpR;
    cyc("r_idle", 1'b1, SIdle);
    cyc("r_fetch", 1'b1, SFetchR);
    cyc("r_decode", 1'b1, SDecode);
    cyc("r_exec", 1'b1, SExecR);
    cyc("r_wb", 1'b1, SAluWb);
    chk_cnt("r_done");

    // OPIMM.
    iOPCODE = OpI;
    cyc("i_fetch", 1'b1, SFetchR);
    cyc("i_decode", 1'b1, SDecode);
    cyc("i_exec", 1'b1, SExecI);
    cyc("i_wb", 1'b1, SAluWb);

    // LOAD with two wait cycles in FETCH and MEM_RD; opcode garbage while fetching.
    ir_pulses = 0;
    iOPCODE = OpX;
    cyc("ld_fw1", 1'b0, SFetchW);
    cyc("ld_fw2", 1'b0, SFetchW);
    cyc("ld_fetch", 1'b1, SFetchR);
    iOPCODE = OpLd;
    cyc("ld_decode", 1'b1, SDecode);
    cyc("ld_adr", 1'b1, SMemAdr);
    cyc("ld_rw1", 1'b0, SMemRd);
    cyc("ld_rw2", 1'b0, SMemRd);
    cyc("ld_rd", 1'b1, SMemRd);
    cyc("ld_wb", 1'b1, SMemWb);
    check("ld_irw_pulses", ir_pulses, 1);
    chk_cnt("ld_done");

    // BRANCH taken then not taken.
    iOPCODE = OpBr;
    iZero = 1'b1;
    cyc("bt_fetch", 1'b1, SFetchR);
    cyc("bt_decode", 1'b1, SDecode);
    cyc("bt_branch", 1'b1, SBrT);
    iZero = 1'b0;
    cyc("bn_fetch", 1'b1, SFetchR);
    cyc("bn_decode", 1'b1, SDecode);
    cyc("bn_branch", 1'b1, SBrN);

    // STORE with one write wait, then JAL.
    iOPCODE = OpSt;
    cyc("st_fetch", 1'b1, SFetchR);
    cyc("st_decode", 1'b1, SDecode);
    cyc("st_adr", 1'b1, SMemAdr);
    cyc("st_ww", 1'b0, SMemWr);
    cyc("st_wr", 1'b1, SMemWr);
    iOPCODE = OpJ;
    cyc("j_fetch", 1'b1, SFetchR);
    cyc("j_decode", 1'b1, SDecode);
    cyc("j_jal", 1'b1, SJal);
    chk_cnt("j_done");

    // Illegal opcode: trap for 20 cycles regardless of inputs; counters frozen.
    iOPCODE = OpX;
    cyc("x_fetch", 1'b1, SFetchR);
    cyc("x_decode", 1'b1, SDecode);
    for (int k = 0; k < 20; k++) begin
      iZero   = k[0];
      iOPCODE = (k[1]) ? OpR : OpX;
      cyc("x_trap", k[0], STrap);
    end
    chk_cnt("x_frozen");
    do_reset("trap_reset");
    cyc("x_idle", 1'b1, SIdle);

    // Reset in the middle of a MEM_RD wait.
    iOPCODE = OpLd;
    cyc("rr_fetch", 1'b1, SFetchR);
    cyc("rr_decode", 1'b1, SDecode);
    cyc("rr_adr", 1'b1, SMemAdr);
    cyc("rr_rw", 1'b0, SMemRd);
    iMemReady = 1'b0;
    do_reset("rd_reset");
    cyc("rr_idle", 1'b1, SIdle);
    cyc("rr_fetch2", 1'b1, SFetchR);
    chk_cnt("rr_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
